demux4_4bit: RTL and testbench

//   Registered 1-to-4 demultiplexer. It routes one WIDTH-bit input stream to one of four

---
 rtl/demux4_4bit.sv | 126 ++++++++++++
 tb/tb_demux4_4bit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/demux4_4bit.sv
// Registered 1-to-4 demultiplexer with per-channel one-entry holding registers and
// valid/ready handshakes; a broadcast mode writes all four channels together.

// Two-to-four one-hot decoder used to derive the channel enables from s.
module demux4_dec2to4 (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);
  always_comb begin
    onehot = 4'b0000;
    onehot[sel] = 1'b1;
  end
endmodule

// One storage bit: a 2:1 hold/load mux feeding a D flip-flop with synchronous reset.
module demux4_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d,
  output logic q
);
  logic q_next;

  // NOTE: give a combinational output a value on every path (here in one
  // expression) so no latch is inferred.
  always_comb q_next = load ? d : q;

  // NOTE: flops use non-blocking assignments so every register samples the
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= q_next;
  end
endmodule

// One output channel: WIDTH data cells plus the valid (FULL/EMPTY) flag.
module demux4_channel #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  logic valid_next;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    demux4_bit_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .d     (d[b]),
      .q     (data[b])
    );
  end

  // A push keeps the channel full even when the old beat is popped in the
  // same cycle; otherwise a pop empties it and the data bits simply hold.
  always_comb valid_next = load | (valid & ~ready);

  always_ff @(posedge clk) begin
    if (!rst_n) valid <= 1'b0;
    else        valid <= valid_next;
  end
endmodule

module demux4_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       s,
  input  logic             bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);
  logic [3:0]       sel_onehot;
  logic [3:0]       chan_en;
  logic [3:0]       acc;
  logic [3:0]       load;
  logic             push;
  logic [WIDTH-1:0] data [4];

  demux4_dec2to4 u_dec (
    .sel    (s),
    .onehot (sel_onehot)
  );

  // in_ready is built only from s, bcast and the channel handshake state, so
  // there is no path from in_valid back to in_ready.
  always_comb begin
    chan_en  = sel_onehot | {4{bcast}};
    acc      = ~out_valid | out_ready;
    in_ready = bcast ? (&acc) : (|(sel_onehot & acc));
    push     = in_valid & in_ready;
    load     = chan_en & {4{push}};
  end

  for (genvar k = 0; k < 4; k++) begin : g_chan
    demux4_channel #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .d     (in),
      .ready (out_ready[k]),
      .data  (data[k]),
      .valid (out_valid[k])
    );
  end

  assign out0 = data[0];
  assign out1 = data[1];
  assign out2 = data[2];
  assign out3 = data[3];
endmodule

// File: tb/tb_demux4_4bit.sv
// Self-checking bench for demux4_4bit: directed vector table, hand-written reset
// sequences, and randomized traffic checked against a channel-level reference model.
module tb_demux4_4bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic [1:0] s;
  logic       bcast;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state: what each consumer should currently see.
  logic [3:0] m_data  [4];
  logic       m_valid [4];

  always #5 clk = ~clk;

  demux4_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .s         (s),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [3:0]  in;
    logic [1:0]  s;
    logic        bcast;
    logic        in_valid;
    logic [3:0]  out_ready;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [15:0] exp_data;   // {out3, out2, out1, out0}
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] outs();
    return {out3, out2, out1, out0};
  endfunction

  task automatic drive(input logic [3:0] d, input logic [1:0] sel, input logic b,
                       input logic iv, input logic [3:0] ordy);
    in = d; s = sel; bcast = b; in_valid = iv; out_ready = ordy;
  endtask

  // Spec-level model: decide acceptance from the rules, then apply push/pop per channel.
  function automatic logic model_ready();
    logic all_ok = 1'b1;
    for (int k = 0; k < 4; k++)
      if (m_valid[k] && !out_ready[k]) all_ok = 1'b0;
    if (bcast) return all_ok;
    return !m_valid[s] || out_ready[s];
  endfunction

  task automatic model_step(input logic rst);
    logic accepted = in_valid && model_ready();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_data[k] = '0; m_valid[k] = 1'b0;
      end else if (accepted && (bcast || s == k[1:0])) begin
        m_data[k] = in; m_valid[k] = 1'b1;
      end else if (m_valid[k] && out_ready[k]) begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  vec_t vecs [11];

  initial begin
    // Tests 2-5 from a reset state, in order; each row is one clock.
    vecs[0]  = '{4'hA, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
    vecs[1]  = '{4'h5, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100, 16'h0A00};
    vecs[2]  = '{4'h5, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'h0500};
    vecs[3]  = '{4'h0, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0500};
    vecs[4]  = '{4'h3, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'h3333};
    vecs[5]  = '{4'h7, 2'd1, 1'b1, 1'b1, 4'b1101, 1'b0, 4'b0010, 16'h3333};
    vecs[6]  = '{4'h0, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h3333};
    vecs[7]  = '{4'h1, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 16'h3331};
    vecs[8]  = '{4'h2, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 16'h3321};
    vecs[9]  = '{4'h3, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 16'h3323};
    vecs[10] = '{4'h4, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 16'h3343};

    // Reset held for two clocks.
    rst_n = 1'b0;
    drive(4'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 4'b0000);
    check("reset_data", outs(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].in, vecs[i].s, vecs[i].bcast, vecs[i].in_valid, vecs[i].out_ready);
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), outs(), vecs[i].exp_data);
    end

    // Build out_valid=1011 (ch1 already full from the table), then reset during a push.
    @(negedge clk); drive(4'h6, 2'd0, 1'b0, 1'b1, 4'b0000);
    @(negedge clk); drive(4'h8, 2'd3, 1'b0, 1'b1, 4'b0000);
    @(posedge clk); #1;
    check("midrst_setup_valid", out_valid, 4'b1011);
    check("midrst_setup_data", outs(), 16'h8346);
    @(negedge clk);
    drive(4'h9, 2'd2, 1'b0, 1'b1, 4'b1111);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", out_valid, 4'b0000);
    check("midrst_data", outs(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h0, 2'd0, 1'b0, 1'b0, 4'b0000);

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 4; k++) begin m_data[k] = '0; m_valid[k] = 1'b0; end
    for (int n = 0; n < 400; n++) begin
      logic rst;
      @(negedge clk);
      rst = ($urandom_range(0, 31) == 0);
      rst_n = !rst;
      drive(4'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), 4'($urandom));
      #1;
      check("rand_in_ready", in_ready, model_ready());
      model_step(rst);
      @(posedge clk); #1;
      check("rand_out_valid", out_valid, {m_valid[3], m_valid[2], m_valid[1], m_valid[0]});
      check("rand_data", outs(), {m_data[3], m_data[2], m_data[1], m_data[0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
